// File: rtl/audio_pkg.sv
// Shared audio definitions: envelope state encoding and the unsigned-sample midpoint.
package audio_pkg;

  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_t;

  // Zero point of an unsigned, midpoint-centred sample of the given width.
  function automatic int midpoint(input int bitdepth);
    return (1 << (bitdepth - 1)) - 1;
  endfunction

endpackage

// File: rtl/envelope_vca.sv
// Two-stage VCA: recentre and capture the level, then multiply, rescale, recentre and saturate.
module envelope_vca
  import audio_pkg::*;
#(
  parameter int BITDEPTH = 14,
  parameter int ENVDEPTH = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BITDEPTH-1:0] sample_in,
  input  logic [ENVDEPTH-1:0] level,
  output logic [BITDEPTH-1:0] sample_out
);

  localparam int PW  = BITDEPTH + ENVDEPTH + 2;
  localparam int MID = midpoint(BITDEPTH);
  localparam logic signed [PW-1:0] OUT_MAX = PW'((1 << BITDEPTH) - 1);

  logic signed [BITDEPTH:0] s_r;
  logic [ENVDEPTH-1:0]      e_r;
  logic signed [PW-1:0]     s_ext, e_ext, prod, shifted, sum;
  logic [BITDEPTH-1:0]      sat_out;

  always_comb begin
    s_ext   = PW'(s_r);
    e_ext   = PW'($signed({1'b0, e_r}));
    prod    = s_ext * e_ext;
    // Arithmetic shift floors toward -inf, so negative swings land one LSB lower.
    shifted = prod >>> ENVDEPTH;
    sum     = shifted + PW'(MID);
    if (sum[PW-1]) begin
      sat_out = '0;
    end else if (sum > OUT_MAX) begin
      sat_out = OUT_MAX[BITDEPTH-1:0];
    end else begin
      sat_out = sum[BITDEPTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_r        <= '0;
      e_r        <= '0;
      sample_out <= BITDEPTH'(MID);
    end else begin
      s_r        <= $signed({1'b0, sample_in}) - (BITDEPTH + 1)'(MID);
      e_r        <= level;
      sample_out <= sat_out;
    end
  end

endmodule

// File: rtl/envelope_adsr.sv
// ADSR envelope generator with gate edge detection, driving the envelope_vca stage.
module envelope_adsr
  import audio_pkg::*;
#(
  parameter int BITDEPTH = 14,
  parameter int ENVDEPTH = 12
) (
  input  logic                sample_clock,
  input  logic                rst,
  input  logic                gate,
  input  logic [7:0]          attack_step,
  input  logic [7:0]          decay_step,
  input  logic [7:0]          sustain_level,
  input  logic [7:0]          release_step,
  input  logic [BITDEPTH-1:0] sample_in,
  output logic [BITDEPTH-1:0] sample_out,
  output logic [ENVDEPTH-1:0] level,
  output logic [2:0]          env_state
);

  localparam int AW = ENVDEPTH + 1;
  localparam logic [AW-1:0] ENVMAX = AW'((1 << ENVDEPTH) - 1);

  env_state_t          state_q, state_d;
  logic [ENVDEPTH-1:0] level_q, level_d;
  logic                gate_d;
  logic                rise, fall;
  // One extra bit of headroom so sums and compares never wrap.
  logic [AW-1:0]       lvl, sus, a, d, r;

  assign rise = gate & ~gate_d;
  assign fall = ~gate & gate_d;

  always_comb begin
    lvl     = {1'b0, level_q};
    sus     = AW'(sustain_level) << (ENVDEPTH - 8);
    a       = AW'(attack_step);
    d       = AW'(decay_step);
    r       = AW'(release_step);
    state_d = state_q;
    level_d = level_q;
    // Gate edges only change state; level keeps its value so retriggers do not click.
    if (rise) begin
      state_d = ENV_ATTACK;
    end else if (fall) begin
      state_d = ENV_RELEASE;
    end else begin
      case (state_q)
        ENV_IDLE: level_d = '0;
        ENV_ATTACK: begin
          if (attack_step == 8'd0 || lvl + a >= ENVMAX) begin
            level_d = ENVMAX[ENVDEPTH-1:0];
            state_d = ENV_DECAY;
          end else begin
            level_d = ENVDEPTH'(lvl + a);
          end
        end
        ENV_DECAY: begin
          if (decay_step == 8'd0 || lvl <= sus + d) begin
            level_d = sus[ENVDEPTH-1:0];
            state_d = ENV_SUSTAIN;
          end else begin
            level_d = ENVDEPTH'(lvl - d);
          end
        end
        ENV_SUSTAIN: level_d = sus[ENVDEPTH-1:0];
        ENV_RELEASE: begin
          if (release_step == 8'd0 || lvl <= r) begin
            level_d = '0;
            state_d = ENV_IDLE;
          end else begin
            level_d = ENVDEPTH'(lvl - r);
          end
        end
        default: begin
          level_d = '0;
          state_d = ENV_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge sample_clock) begin
    if (rst) begin
      state_q <= ENV_IDLE;
      level_q <= '0;
      gate_d  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      gate_d  <= gate;
    end
  end

  assign level     = level_q;
  assign env_state = state_q;

  envelope_vca #(
    .BITDEPTH(BITDEPTH),
    .ENVDEPTH(ENVDEPTH)
  ) u_vca (
    .clk       (sample_clock),
    .rst       (rst),
    .sample_in (sample_in),
    .level     (level_q),
    .sample_out(sample_out)
  );

endmodule

// File: tb/tb_envelope_adsr.sv
// Directed bench for envelope_adsr: envelope model per edge plus an output scoreboard for the VCA.
module tb_envelope_adsr;

  localparam int MID    = 8191;
  localparam int ENVMAX = 4095;

  // clock / reset
  logic        sample_clock = 1'b0;
  logic        rst = 1'b1;
  logic        gate = 1'b0;
  logic [7:0]  attack_step = 8'd0, decay_step = 8'd0, sustain_level = 8'd0, release_step = 8'd0;
  logic [13:0] sample_in = 14'd8191;
  logic [13:0] sample_out;
  logic [11:0] level;
  logic [2:0]  env_state;

  always #5 sample_clock = ~sample_clock;

  envelope_adsr dut (
    .sample_clock (sample_clock),
    .rst          (rst),
    .gate         (gate),
    .attack_step  (attack_step),
    .decay_step   (decay_step),
    .sustain_level(sustain_level),
    .release_step (release_step),
    .sample_in    (sample_in),
    .sample_out   (sample_out),
    .level        (level),
    .env_state    (env_state)
  );

  // scoreboard
  logic [13:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int m_state = 0;
  int m_level = 0;
  bit m_gate_d = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [13:0] vca_model(input int s_in, input int lvl);
    int s, p, o;
    s = s_in - MID;
    p = s * lvl;
    o = MID + (p >>> 12);
    if (o < 0) o = 0;
    if (o > 16383) o = 16383;
    return 14'(o);
  endfunction

  task automatic model_edge();
    bit rise, fall;
    int sus;
    if (rst) begin
      m_state = 0; m_level = 0; m_gate_d = 1'b0;
    end else begin
      rise = gate && !m_gate_d;
      fall = !gate && m_gate_d;
      sus  = int'(sustain_level) * 16;
      if (rise) m_state = 1;
      else if (fall) m_state = 4;
      else begin
        case (m_state)
          0: m_level = 0;
          1: if (attack_step == 0 || m_level + attack_step >= ENVMAX) begin
               m_level = ENVMAX; m_state = 2;
             end else m_level += attack_step;
          2: if (decay_step == 0 || m_level <= sus + decay_step) begin
               m_level = sus; m_state = 3;
             end else m_level -= decay_step;
          3: m_level = sus;
          default: if (release_step == 0 || m_level <= release_step) begin
               m_level = 0; m_state = 0;
             end else m_level -= release_step;
        endcase
      end
      m_gate_d = gate;
    end
  endtask

  // driver: one sample edge, then compare everything observable
  task automatic tick();
    logic [13:0] e;
    if (!rst) exp_q.push_back(vca_model(int'(sample_in), m_level));
    @(posedge sample_clock);
    model_edge();
    #1;
    if (rst) begin
      check("out_rst", 32'(sample_out), 32'(MID));
      exp_q.delete();
      exp_q.push_back(14'(MID));
    end else if (exp_q.size() == 0) begin
      check("sb_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("sample_out", 32'(sample_out), 32'(e));
    end
    check("level", 32'(level), 32'(m_level));
    check("env_state", 32'(env_state), 32'(m_state));
  endtask

  task automatic rand_in();
    sample_in = 14'($urandom_range(0, 16383));
  endtask

  initial begin
    // Reset with gate held high
    rst = 1'b1; gate = 1'b1;
    tick(); tick();
    check("rst_out", 32'(sample_out), 32'd8191);
    check("rst_level", 32'(level), 32'd0);
    check("rst_state", 32'(env_state), 32'd0);
    gate = 1'b0; rst = 1'b0;
    tick();

    // Attack at 64 per edge
    attack_step = 8'd64; decay_step = 8'd16; sustain_level = 8'h80; release_step = 8'd8;
    gate = 1'b1; rand_in();
    tick();
    check("atk_e0_state", 32'(env_state), 32'd1);
    check("atk_e0_level", 32'(level), 32'd0);
    for (int k = 1; k <= 63; k++) begin
      rand_in(); tick();
      check("atk_level", 32'(level), 32'(64 * k));
    end
    tick();
    check("atk_top_level", 32'(level), 32'd4095);
    check("atk_top_state", 32'(env_state), 32'd2);

    // Decay to sustain 0x80
    for (int k = 1; k <= 127; k++) begin
      rand_in(); tick();
    end
    tick();
    check("dec_level", 32'(level), 32'd2048);
    check("dec_state", 32'(env_state), 32'd3);
    sustain_level = 8'h40; tick();
    check("sus_track", 32'(level), 32'd1024);
    sustain_level = 8'h80; tick();
    check("sus_back", 32'(level), 32'd2048);

    // VCA at level 2048
    sample_in = 14'd16383; tick(); tick();
    check("vca_max", 32'(sample_out), 32'd12287);
    sample_in = 14'd0; tick(); tick();
    check("vca_min", 32'(sample_out), 32'd4095);
    sample_in = 14'd8191; tick(); tick();
    check("vca_mid", 32'(sample_out), 32'd8191);

    // Release to idle, then attack to 1000 and release mid-attack
    gate = 1'b0; release_step = 8'd64;
    for (int k = 0; k < 100 && !(k > 0 && m_state == 0); k++) begin
      rand_in(); tick();
    end
    check("rel_idle", 32'(env_state), 32'd0);
    attack_step = 8'd100; gate = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      rand_in(); tick();
    end
    check("atk_1000", 32'(level), 32'd1000);
    gate = 1'b0; release_step = 8'd8; tick();
    check("rel_enter_state", 32'(env_state), 32'd4);
    check("rel_enter_level", 32'(level), 32'd1000);
    for (int k = 1; k <= 124; k++) begin
      rand_in(); tick();
    end
    check("rel_124", 32'(level), 32'd8);
    tick();
    check("rel_end_level", 32'(level), 32'd0);
    check("rel_end_state", 32'(env_state), 32'd0);
    rand_in(); tick(); tick();
    check("rel_out_mid", 32'(sample_out), 32'd8191);

    // Retrigger during release at 500
    gate = 1'b1;
    for (int k = 0; k <= 5; k++) tick();
    check("pre_retrig", 32'(level), 32'd500);
    gate = 1'b0; tick();
    check("retrig_rel", 32'(env_state), 32'd4);
    gate = 1'b1; tick();
    check("retrig_state", 32'(env_state), 32'd1);
    check("retrig_level", 32'(level), 32'd500);
    tick();
    check("retrig_step", 32'(level), 32'd600);

    // Zero-step boundaries jump straight to the target
    attack_step = 8'd0; tick();
    check("atk0", 32'(level), 32'd4095);
    decay_step = 8'd0; sustain_level = 8'h33; tick();
    check("dec0", 32'(level), 32'(8'h33 * 16));
    gate = 1'b0; release_step = 8'd0; tick(); tick();
    check("rel0", 32'(level), 32'd0);
    tick();
    check("gate_low_idle", 32'(env_state), 32'd0);

    // Reset mid-attack
    attack_step = 8'd10; gate = 1'b1; tick(); tick(); tick();
    check("pre_abort", 32'(level), 32'd20);
    rst = 1'b1; gate = 1'b0; tick();
    check("abort_state", 32'(env_state), 32'd0);
    check("abort_level", 32'(level), 32'd0);
    rst = 1'b0; rand_in(); tick(); tick();
    check("abort_out", 32'(sample_out), 32'd8191);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
